// File: rtl/mem_arb.sv
// ============================================================================
// Module   : mem_arb
// Brief    : Two-port arbiter in front of a single-port memory with
//            registered outputs, fixed-priority plus starvation guard, or
//            round-robin arbitration when MEM_ARB_RR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [2:0] c_wait_last  = 3'(MEM_LAT - 1);
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    state_t      r_state;
    state_t      w_nxt_state;

    logic        r_win;
    logic        r_we;
    logic [2:0]  r_wait_cnt;

    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_busy;

    logic        w_any_req;
    logic        w_pick1;
    logic        w_start;
    logic        w_sel_we;
    logic [15:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_wait_last;
    logic        w_capture;

    logic        w_nxt_gnt0;
    logic        w_nxt_gnt1;
    logic        w_nxt_rvalid0;
    logic        w_nxt_rvalid1;
    logic        w_nxt_mem_en;
    logic        w_nxt_mem_we;
    logic [15:0] w_nxt_mem_addr;
    logic [31:0] w_nxt_mem_wdata;
    logic        w_nxt_busy;

`ifdef MEM_ARB_RR_EN
    // r_rr_ptr = 1 means port 1 wins the next contended arbitration.
    logic        r_rr_ptr;

    always_comb begin
        w_pick1 = req1 && (!req0 || r_rr_ptr);
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_rr_ptr <= 1'b0;
        end else if (w_start) begin
            r_rr_ptr <= !w_pick1;
        end
    end
`else
    logic [3:0]  r_starve;
    logic        w_starved;

    always_comb begin
        w_starved = (r_starve == c_starve_max);
        w_pick1   = req1 && !(req0 && w_starved);
    end

    // Counts arbitrations port 0 lost; cleared as soon as port 0 wins.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_starve <= 4'd0;
        end else if (w_start && req0) begin
            if (!w_pick1) begin
                r_starve <= 4'd0;
            end else if (r_starve != 4'hF) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_any_req   = req0 || req1;
        w_start     = (r_state == S_IDLE) && w_any_req;
        w_sel_we    = w_pick1 ? we1    : we0;
        w_sel_addr  = w_pick1 ? addr1  : addr0;
        w_sel_wdata = w_pick1 ? wdata1 : wdata0;
        w_wait_last = (r_wait_cnt == c_wait_last);
        w_capture   = (r_state == S_WAIT) && w_wait_last;

        w_nxt_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_nxt_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_nxt_state = r_we ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (w_wait_last) begin
                    w_nxt_state = S_RESP;
                end
            end
            S_RESP: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase

        w_nxt_gnt0      = w_start && !w_pick1;
        w_nxt_gnt1      = w_start && w_pick1;
        w_nxt_mem_en    = w_start;
        w_nxt_mem_we    = w_start && w_sel_we;
        w_nxt_mem_addr  = w_start ? w_sel_addr  : 16'd0;
        w_nxt_mem_wdata = w_start ? w_sel_wdata : 32'd0;
        w_nxt_rvalid0   = w_capture && !r_win;
        w_nxt_rvalid1   = w_capture && r_win;
        w_nxt_busy      = (w_nxt_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_win      <= 1'b0;
            r_we       <= 1'b0;
            r_wait_cnt <= 3'd0;
        end else begin
            if (w_start) begin
                r_win <= w_pick1;
                r_we  <= w_sel_we;
            end
            if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 3'd1;
            end else begin
                r_wait_cnt <= 3'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= 32'd0;
            r_rdata1    <= 32'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'd0;
            r_mem_wdata <= 32'd0;
            r_busy      <= 1'b0;
        end else begin
            r_gnt0      <= w_nxt_gnt0;
            r_gnt1      <= w_nxt_gnt1;
            r_rvalid0   <= w_nxt_rvalid0;
            r_rvalid1   <= w_nxt_rvalid1;
            r_mem_en    <= w_nxt_mem_en;
            r_mem_we    <= w_nxt_mem_we;
            r_mem_addr  <= w_nxt_mem_addr;
            r_mem_wdata <= w_nxt_mem_wdata;
            r_busy      <= w_nxt_busy;
            // Read data is held until the next read completes on that port.
            if (w_nxt_rvalid0) begin
                r_rdata0 <= mem_rdata;
            end
            if (w_nxt_rvalid1) begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

    a_one_gnt: assert property (@(posedge clk) disable iff (rst_f)
        !(r_gnt0 && r_gnt1));
    a_one_rvalid: assert property (@(posedge clk) disable iff (rst_f)
        !(r_rvalid0 && r_rvalid1));

endmodule

`default_nettype wire
